muldiv_seq: RTL and testbench

Multi-cycle multiply/divide sequencer for the EX stage. It accepts MULT, MULTU, DIV and DIVU issued alongside the single-cycle ALU and iterates a shift-add or restoring-divide datapath for 32 cycles. It owns the HI/LO architectural registers and drives the EX stall request to the hazard unit until the result is committed.

---
 rtl/mips_pkg.sv | 26 ++
 rtl/muldiv_seq.sv | 136 +++++++++++++
 tb/tb_muldiv_seq.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the EX-stage multiply/divide sequencer.
package mips_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } muldivOp_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_CALC,
        ST_FIX,
        ST_DONE
    } muldivState_e;

    function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v, input logic signedOp);
        return (signedOp && v[WIDTH-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; stalls EX until commit.
//   state | meaning
//   IDLE  | waiting for start
//   PREP  | take magnitudes, record signs, catch divide-by-zero
//   CALC  | one shift-add / restoring-divide step per cycle
//   FIX   | apply result signs, stage HI/LO write
//   DONE  | done pulse, HI/LO visible
module muldiv_seq
    import mips_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] dataRs,
    input  logic [WIDTH-1:0] dataRt,
    input  logic             abort,
    output logic [WIDTH-1:0] outHi,
    output logic [WIDTH-1:0] outLo,
    output logic             busy,
    output logic             done,
    output logic             stallEx,
    output logic             divByZero
);

    muldivState_e       state, stateNext;
    muldivOp_e          opReg;
    logic [WIDTH-1:0]   rsReg, rtReg;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic               signRes, signRem;

    logic               isDiv, isSigned, rtZero;
    logic [WIDTH:0]     mulSum, divShift, divDiff;
    logic [2*WIDTH-1:0] mulStep, divStep, prodFix;
    logic [WIDTH-1:0]   fixHi, fixLo;

    assign isDiv    = (opReg == OP_DIV) || (opReg == OP_DIVU);
    assign isSigned = (opReg == OP_MULT) || (opReg == OP_DIV);
    assign rtZero   = (rtReg == '0);

    // acc holds {partial product, remaining multiplier} or {remainder, dividend/quotient}
    assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, rsReg} : '0);
    assign mulStep  = {mulSum, acc[WIDTH-1:1]};
    assign divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, rtReg};
    assign divStep  = divDiff[WIDTH] ? {divShift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {divDiff[WIDTH-1:0],  acc[WIDTH-2:0], 1'b1};

    // signRes/signRem are only ever set for signed ops, so unsigned passes through
    assign prodFix = signRes ? -acc : acc;

    always_comb begin
        fixHi = prodFix[2*WIDTH-1:WIDTH];
        fixLo = prodFix[WIDTH-1:0];
        if (isDiv) begin
            fixLo = signRes ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            fixHi = signRem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: if (start && !abort) stateNext = ST_PREP;
            ST_PREP: begin
                if (abort)               stateNext = ST_IDLE;
                else if (isDiv && rtZero) stateNext = ST_DONE;
                else                     stateNext = ST_CALC;
            end
            ST_CALC: begin
                if (abort)          stateNext = ST_IDLE;
                else if (cnt == '0) stateNext = ST_FIX;
            end
            ST_FIX:  stateNext = abort ? ST_IDLE : ST_DONE;
            ST_DONE: stateNext = ST_IDLE;
            default: stateNext = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= stateNext;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            opReg     <= OP_MULT;
            rsReg     <= '0;
            rtReg     <= '0;
            acc       <= '0;
            cnt       <= '0;
            signRes   <= 1'b0;
            signRem   <= 1'b0;
            outHi     <= '0;
            outLo     <= '0;
            divByZero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        opReg     <= muldivOp_e'(op);
                        rsReg     <= dataRs;
                        rtReg     <= dataRt;
                        divByZero <= 1'b0;
                    end
                end
                ST_PREP: begin
                    rsReg   <= absVal(rsReg, isSigned);
                    rtReg   <= absVal(rtReg, isSigned);
                    acc     <= {{WIDTH{1'b0}}, isDiv ? absVal(rsReg, isSigned) : absVal(rtReg, isSigned)};
                    signRes <= isSigned && (rsReg[WIDTH-1] ^ rtReg[WIDTH-1]);
                    signRem <= isSigned && rsReg[WIDTH-1];
                    cnt     <= CNT_W'(WIDTH - 1);
                    if (!abort && isDiv && rtZero) divByZero <= 1'b1;
                end
                ST_CALC: begin
                    cnt <= cnt - CNT_W'(1);
                    acc <= isDiv ? divStep : mulStep;
                end
                ST_FIX: begin
                    if (!abort) begin
                        outHi <= fixHi;
                        outLo <= fixLo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = (state == ST_PREP) || (state == ST_CALC) || (state == ST_FIX);
    assign done    = (state == ST_DONE);
    assign stallEx = (start && state == ST_IDLE) || busy;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed scoreboard bench for muldiv_seq: results checked by a done-triggered monitor.
module tb_muldiv_seq;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    logic        clk, reset, start, abort;
    logic [1:0]  op;
    logic [31:0] dataRs, dataRt, outHi, outLo;
    logic        busy, done, stallEx, divByZero;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    muldiv_seq dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .dataRs(dataRs), .dataRt(dataRt), .abort(abort),
        .outHi(outHi), .outLo(outLo), .busy(busy), .done(done),
        .stallEx(stallEx), .divByZero(divByZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_hi"},    64'(outHi),     64'(e.hi));
                check({e.name, "_lo"},    64'(outLo),     64'(e.lo));
                check({e.name, "_dbz"},   64'(divByZero), 64'(e.dbz));
                check({e.name, "_cycle"}, 64'(cyc),       64'(e.cyc));
            end
        end
    end

    // Called at a negedge in IDLE; returns just after the accept edge (cycle 1).
    task automatic issue(input string name, input logic [1:0] o, input logic [31:0] rs, input logic [31:0] rt,
                         input logic push, input logic [31:0] eHi, input logic [31:0] eLo,
                         input logic eDbz, input int lat);
        exp_t e;
        start = 1'b1; op = o; dataRs = rs; dataRt = rt;
        #1 check({name, "_stall_c0"}, 64'(stallEx), 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0; dataRs = 32'hDEAD_BEEF; dataRt = 32'h0BAD_F00D;
        if (push) begin
            e.name = name; e.hi = eHi; e.lo = eLo; e.dbz = eDbz; e.cyc = cyc + lat - 1;
            sb.push_back(e);
        end
    endtask

    task automatic busyWindow(input string name, input int n);
        int bad = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (busy !== 1'b1 || stallEx !== 1'b1) bad++;
        end
        @(negedge clk);
        if (busy !== 1'b0) bad++;
        check({name, "_busy_window"}, 64'(bad), 64'd0);
    endtask

    task automatic waitIdle(input string name);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((busy || done) && k < 100);
        if (busy || done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got busy=%0b done=%0b expected idle within 100 cycles", name, busy, done);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; op = 2'b00; dataRs = '0; dataRt = '0;
        repeat (3) @(negedge clk);
        check("rst_hi",   64'(outHi),     64'd0);
        check("rst_lo",   64'(outLo),     64'd0);
        check("rst_busy", 64'(busy),      64'd0);
        check("rst_done", 64'(done),      64'd0);
        check("rst_dbz",  64'(divByZero), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        issue("mult_7_m3", MULT, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 35);
        busyWindow("mult_7_m3", 34);
        waitIdle("mult_7_m3");

        issue("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 35);
        waitIdle("multu_max");

        issue("div_min_m1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0, 32'h8000_0000, 1'b0, 35);
        waitIdle("div_min_m1");

        issue("divu_preload", DIVU, 32'h5678_1234, 32'h0001_0000, 1'b1, 32'h1234, 32'h5678, 1'b0, 35);
        waitIdle("divu_preload");

        issue("divu_by0", DIVU, 32'd5, 32'd0, 1'b1, 32'h1234, 32'h5678, 1'b1, 2);
        busyWindow("divu_by0", 1);
        waitIdle("divu_by0");
        check("dbz_held_idle", 64'(divByZero), 64'd1);

        issue("divu_100_7", DIVU, 32'd100, 32'd7, 1'b1, 32'd2, 32'd14, 1'b0, 35);
        check("dbz_cleared", 64'(divByZero), 64'd0);
        waitIdle("divu_100_7");

        // Extra starts while busy (cycle 10) and in DONE (cycle 35) must be dropped.
        issue("multu_3_5", MULTU, 32'd3, 32'd5, 1'b1, 32'd0, 32'd15, 1'b0, 35);
        repeat (10) @(negedge clk);
        start = 1'b1; op = DIVU; dataRs = 32'd9; dataRt = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (24) @(negedge clk);
        check("poke_in_done_cycle", 64'(done), 64'd1);
        start = 1'b1; op = MULT; dataRs = 32'd11; dataRt = 32'd13;
        @(negedge clk);
        start = 1'b0;
        #1 check("start_in_done_ignored", 64'(busy), 64'd0);
        waitIdle("multu_3_5");

        issue("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 35);
        waitIdle("div_m7_2");

        issue("abort_mult", MULT, 32'd1234, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 35);
        repeat (19) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_c21", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        check("abort_hi_kept", 64'(outHi), 64'hFFFF_FFFF);
        check("abort_lo_kept", 64'(outLo), 64'hFFFF_FFFD);

        start = 1'b1; abort = 1'b1; op = MULTU; dataRs = 32'd2; dataRt = 32'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);
        check("start_abort_lo_kept", 64'(outLo), 64'hFFFF_FFFD);

        issue("reset_multu", MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'd0, 32'd0, 1'b0, 35);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        #1;
        check("midrst_hi",    64'(outHi),   64'd0);
        check("midrst_lo",    64'(outLo),   64'd0);
        check("midrst_busy",  64'(busy),    64'd0);
        check("midrst_done",  64'(done),    64'd0);
        check("midrst_stall", 64'(stallEx), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);

        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
